// File: rtl/router_sync_n_pkg.sv
// Shared defaults and address-error convention for the
// router output-channel synchroniser.
package router_sync_n_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_TIMEOUT = 30;

  localparam logic ADDR_OK  = 1'b0;
  localparam logic ADDR_BAD = 1'b1;

  function automatic logic addr_check(int addr, int num_ch);
    return (addr >= num_ch) ? ADDR_BAD : ADDR_OK;
  endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// Per-channel read-timeout watchdog; pulses soft_reset
// after TIMEOUT consecutive valid-but-unread cycles.
module router_sync_wdog #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Synchroniser between the router FSM and NUM_CH output
// FIFOs: address latch, write steering, watchdogs.
module router_sync_n
  import router_sync_n_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = ROUTER_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg <= '0;
      addr_err <= ADDR_OK;
    end else if (detect_add) begin
      addr_reg <= data_in;
      addr_err <= addr_check(int'(data_in), NUM_CH);
    end
  end

  // A bad address reports not-full so the FSM drains and drops it.
  always_comb begin
    fifo_full = 1'b0;
    write_enb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!addr_err && addr_reg == ADDR_W'(i)) begin
        fifo_full    = full[i];
        write_enb[i] = write_enb_reg;
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    router_sync_wdog #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_wdog (
      .clk       (clk),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .rd        (read_enb[g]),
      .soft_reset(soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: expectations queued
// at stimulus time, popped when outputs are sampled.
module tb_router_sync_n;

  logic       clk = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] full, empty, read_enb;
  logic       fifo_full, addr_err;
  logic [2:0] write_enb, vld_out, soft_reset;

  logic       detect_add5;
  logic [2:0] data_in5;
  logic       write_enb_reg5;
  logic       fifo_full5, addr_err5;
  logic [4:0] write_enb5, vld_out5, soft_reset5;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  router_sync_n dut (
    .clk          (clk),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .full         (full),
    .empty        (empty),
    .read_enb     (read_enb),
    .fifo_full    (fifo_full),
    .write_enb    (write_enb),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .addr_err     (addr_err)
  );

  router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(30)) dut5 (
    .clk          (clk),
    .resetn       (resetn),
    .detect_add   (detect_add5),
    .data_in      (data_in5),
    .write_enb_reg(write_enb_reg5),
    .full         (5'b00000),
    .empty        (5'b11111),
    .read_enb     (5'b00000),
    .fifo_full    (fifo_full5),
    .write_enb    (write_enb5),
    .vld_out      (vld_out5),
    .soft_reset   (soft_reset5),
    .addr_err     (addr_err5)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input string n, input logic [7:0] v);
    sb_t e;
    e.name = n;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    sb_t e;
    logic [7:0] obs;
    resetn        = 1'b0;
    detect_add    = 1'b0;
    data_in       = 2'd0;
    write_enb_reg = 1'b0;
    full          = 3'b001;
    empty         = 3'b111;
    read_enb      = 3'b000;
    detect_add5   = 1'b0;
    data_in5      = 3'd0;
    write_enb_reg5 = 1'b0;
    cyc();
    push("rst_addr_err", 8'd0);
    push("rst_soft_reset", 8'd0);
    push("rst_fifo_full0", 8'd1);
    push("rst_write_enb", 8'd1);
    push("rst_vld_out", 8'd0);
    write_enb_reg = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      e = sb_q.pop_front();
      case (i)
        0: obs = {7'd0, addr_err};
        1: obs = {5'd0, soft_reset};
        2: obs = {7'd0, fifo_full};
        3: obs = {5'd0, write_enb};
        default: obs = {5'd0, vld_out};
      endcase
      total++;
      if (obs !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, obs, e.exp);
      else
        passed++;
    end
    write_enb_reg = 1'b0;
    full = 3'b000;
    resetn = 1'b1;
  endtask

  task automatic test_reset_mid();
    sb_t e;
    empty[1] = 1'b0;
    for (int k = 1; k <= 20; k++) cyc();
    resetn = 1'b0;
    #2;
    push("mid_rst_pulse", 8'd0);
    e = sb_q.pop_front();
    total++;
    if ({5'd0, soft_reset} !== e.exp)
      $display("FAIL %s: got %0h want %0h", e.name, soft_reset, e.exp);
    else
      passed++;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 31; k++)
      push($sformatf("mid_rst_k%0d", k), (k == 30) ? 8'h02 : 8'h00);
    for (int k = 1; k <= 31; k++) begin
      cyc();
      e = sb_q.pop_front();
      total++;
      if ({5'd0, soft_reset} !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, soft_reset, e.exp);
      else
        passed++;
    end
    empty = 3'b111;
    cyc();
  endtask

  task automatic test_steer();
    sb_t e;
    logic [7:0] obs;
    detect_add = 1'b1;
    data_in    = 2'd2;
    cyc();
    detect_add    = 1'b0;
    data_in       = 2'd0;
    write_enb_reg = 1'b1;
    full          = 3'b100;
    push("steer_write_enb", 8'h04);
    push("steer_full_hi", 8'h01);
    push("steer_addr_err", 8'h00);
    push("steer_full_lo", 8'h00);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        full = 3'b000;
        #1;
      end
      e = sb_q.pop_front();
      case (i)
        0: obs = {5'd0, write_enb};
        1: obs = {7'd0, fifo_full};
        2: obs = {7'd0, addr_err};
        default: obs = {7'd0, fifo_full};
      endcase
      total++;
      if (obs !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, obs, e.exp);
      else
        passed++;
    end
    write_enb_reg = 1'b0;
  endtask

  task automatic test_addr_err();
    sb_t e;
    logic [7:0] obs;
    detect_add = 1'b1;
    data_in    = 2'd3;
    cyc();
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    full          = 3'b111;
    push("err_flag", 8'h01);
    push("err_write_enb", 8'h00);
    push("err_fifo_full", 8'h00);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
      case (i)
        0: obs = {7'd0, addr_err};
        1: obs = {5'd0, write_enb};
        default: obs = {7'd0, fifo_full};
      endcase
      total++;
      if (obs !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, obs, e.exp);
      else
        passed++;
    end
    write_enb_reg = 1'b0;
    detect_add    = 1'b1;
    data_in       = 2'd0;
    cyc();
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    push("err_clear", 8'h00);
    push("ok_write_enb", 8'h01);
    push("ok_fifo_full", 8'h01);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
      case (i)
        0: obs = {7'd0, addr_err};
        1: obs = {5'd0, write_enb};
        default: obs = {7'd0, fifo_full};
      endcase
      total++;
      if (obs !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, obs, e.exp);
      else
        passed++;
    end
    write_enb_reg = 1'b0;
    full = 3'b000;
  endtask

  task automatic test_wdog();
    sb_t e;
    empty[0] = 1'b0;
    for (int k = 1; k <= 65; k++)
      push($sformatf("wdog_k%0d", k),
           (k == 30 || k == 60) ? 8'h01 : 8'h00);
    for (int k = 1; k <= 65; k++) begin
      cyc();
      e = sb_q.pop_front();
      total++;
      if ({5'd0, soft_reset} !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, soft_reset, e.exp);
      else
        passed++;
    end
    empty = 3'b111;
    cyc();
  endtask

  task automatic test_read_clear();
    sb_t e;
    empty[0] = 1'b0;
    for (int k = 1; k <= 61; k++)
      push($sformatf("rdclr_k%0d", k), (k == 60) ? 8'h01 : 8'h00);
    for (int k = 1; k <= 61; k++) begin
      read_enb[0] = (k == 30);
      cyc();
      e = sb_q.pop_front();
      total++;
      if ({5'd0, soft_reset} !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, soft_reset, e.exp);
      else
        passed++;
    end
    read_enb = 3'b000;
    empty = 3'b111;
    cyc();
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [7:0] obs;
    detect_add    = 1'b1;
    data_in       = 2'd1;
    write_enb_reg = 1'b1;
    detect_add5   = 1'b1;
    data_in5      = 3'd4;
    push("b2b_old_addr", 8'h01);
    push("b2b_new_addr", 8'h02);
    push("b2b_ch5_write", 8'h10);
    push("b2b_ch5_err", 8'h00);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        cyc();
        detect_add     = 1'b0;
        detect_add5    = 1'b0;
        write_enb_reg5 = 1'b1;
        #1;
      end
      e = sb_q.pop_front();
      case (i)
        0, 1: obs = {5'd0, write_enb};
        2: obs = {3'd0, write_enb5};
        default: obs = {7'd0, addr_err5};
      endcase
      total++;
      if (obs !== e.exp)
        $display("FAIL %s: got %0h want %0h", e.name, obs, e.exp);
      else
        passed++;
    end
    write_enb_reg  = 1'b0;
    write_enb_reg5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_steer();
    test_addr_err();
    test_wdog();
    test_read_clear();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain: got %0d want 0", sb_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
